// File: rtl/ifetch_queue.sv
// Instruction fetch queue: fetches sequential words into a small circular buffer
// that a decode stage drains; a redirect flushes the buffer and restarts fetch.
module ifetch_queue #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  output logic                         imem_req,
  output logic [XLEN-1:0]              imem_addr,
  input  logic [31:0]                  imem_rdata,
  input  logic                         redirect,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [31:0]                  out_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic            push;
  logic            pop;

  // A full queue never fetches, even if the head leaves this cycle.
  assign push      = en & ~rst & ~redirect & (count < FULL);
  assign pop       = en & ~rst & ~redirect & out_valid & out_ready;
  assign imem_req  = push;
  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign out_pc    = pc_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (en) begin
      if (redirect) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + PW'(1);
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the entry storage has no reset; count and pointers alone decide
  // which entries are meaningful, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: a queue-based reference model checked
// every cycle, plus directed literal expectations for fill, stream, redirect, stall and wrap.
module tb_ifetch_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst, en, redirect, out_ready;
  logic [31:0] redirect_pc;

  logic        imem_req, out_valid;
  logic [31:0] imem_addr, imem_rdata, out_pc, out_instr;
  logic [2:0]  count;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_pc, w_instr;
  logic [2:0]  w_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  assign imem_rdata = instr_of(imem_addr);
  assign w_rdata    = instr_of(w_addr);

  ifetch_queue dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .count(count)
  );

  ifetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .en(en),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(w_valid), .out_ready(out_ready),
    .out_pc(w_pc), .out_instr(w_instr), .count(w_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of {pc, instr} plus the next fetch address.
  entry_t      q[$];
  logic [31:0] m_pc;
  bit          armed = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_pc  = 32'h0;
      armed = 1;
    end else if (en && armed) begin
      if (redirect) begin
        q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        automatic bit do_push = q.size() < 4;
        automatic bit do_pop  = (q.size() != 0) && out_ready;
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          q.push_back('{pc: m_pc, instr: instr_of(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("model_req",   {31'b0, imem_req},
            {31'b0, en && !rst && !redirect && (q.size() < 4)});
      check("model_addr",  imem_addr, m_pc);
      check("model_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      check("model_count", {29'b0, count}, q.size());
      if (q.size() != 0) begin
        check("model_pc",    out_pc,    q[0].pc);
        check("model_instr", out_instr, q[0].instr);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sp, sa;
  logic [2:0]  sc;
  logic [31:0] rdy_pat = 32'b1011_0010_1110_0101_0110_1001_1100_0111;
  logic [31:0] en_pat  = 32'b1111_1101_1111_0111_1111_1110_0111_1111;

  initial begin
    rst = 1; en = 1; redirect = 0; redirect_pc = 0; out_ready = 0;
    cyc();
    check("rst_req",   {31'b0, imem_req},  0);
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_count", {29'b0, count},     0);
    check("rst_w_valid", {31'b0, w_valid}, 0);

    // Fill with consumer stalled
    rst = 0; #1;
    check("fill_addr0", imem_addr, 32'h0);
    check("fill_req0",  {31'b0, imem_req}, 1);
    check("wrap_addr0", w_addr, 32'hFFFF_FFF8);
    check("wrap_req0",  {31'b0, w_req}, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("fill_addr",  imem_addr, 32'(4 * i));
      check("fill_count", {29'b0, count}, 32'(i));
      check("fill_head",  out_pc, 32'h0);
      if (i == 1) begin
        check("wrap_addr1", w_addr, 32'hFFFF_FFFC);
        check("wrap_head",  w_pc, 32'hFFFF_FFF8);
        check("wrap_instr", w_instr, instr_of(32'hFFFF_FFF8));
      end
      if (i == 2) check("wrap_addr2", w_addr, 32'h0);
    end
    check("full_req",   {31'b0, imem_req}, 0);
    check("head_instr", out_instr, instr_of(32'h0));
    cyc();
    check("full_count", {29'b0, count}, 4);
    check("full_hold",  out_pc, 32'h0);
    check("full_req2",  {31'b0, imem_req}, 0);

    // Mid-stream reset
    rst = 1; #1;
    check("rst_req_mid", {31'b0, imem_req}, 0);
    cyc();
    check("rst_mid_count", {29'b0, count}, 0);
    check("rst_mid_valid", {31'b0, out_valid}, 0);
    check("rst_mid_addr",  imem_addr, 32'h0);
    check("rst_mid_waddr", w_addr, 32'hFFFF_FFF8);
    check("rst_mid_wcnt",  {29'b0, w_count}, 0);

    // Streaming
    rst = 0; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("stream_valid", {31'b0, out_valid}, 1);
      check("stream_pc",    out_pc, 32'(4 * i));
      check("stream_count", {29'b0, count}, 1);
    end

    // Global stall
    en = 0; #1;
    check("stall_req0", {31'b0, imem_req}, 0);
    sc = count; sp = out_pc; sa = imem_addr;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_req",   {31'b0, imem_req}, 0);
      check("stall_count", {29'b0, count}, {29'b0, sc});
      check("stall_pc",    out_pc, sp);
      check("stall_addr",  imem_addr, sa);
    end
    en = 1;
    cyc();
    check("resume_pc", out_pc, sp + 32'd4);

    // Fill, then redirect to a misaligned target
    out_ready = 0;
    repeat (4) cyc();
    check("pre_redir_count", {29'b0, count}, 4);
    redirect = 1; redirect_pc = 32'h0000_0103; #1;
    check("redir_req", {31'b0, imem_req}, 0);
    cyc();
    redirect = 0; #1;
    check("redir_count", {29'b0, count}, 0);
    check("redir_valid", {31'b0, out_valid}, 0);
    check("redir_addr",  imem_addr, 32'h0000_0100);
    check("redir_req2",  {31'b0, imem_req}, 1);
    cyc();
    check("redir_head",  out_pc, 32'h0000_0100);

    // Redirect colliding with push and pop
    out_ready = 1;
    cyc();
    check("coll_pre_count", {29'b0, count}, 1);
    redirect = 1; redirect_pc = 32'h0000_0200;
    cyc();
    redirect = 0; #1;
    check("coll_count", {29'b0, count}, 0);
    check("coll_addr",  imem_addr, 32'h0000_0200);
    cyc();
    check("coll_head0", out_pc, 32'h0000_0200);
    cyc();
    check("coll_head1", out_pc, 32'h0000_0204);

    // Address wrap through redirect
    redirect = 1; redirect_pc = 32'hFFFF_FFF9;
    cyc();
    redirect = 0;
    cyc();
    check("wrapr_pc0", out_pc, 32'hFFFF_FFF8);
    cyc();
    check("wrapr_pc1", out_pc, 32'hFFFF_FFFC);
    cyc();
    check("wrapr_pc2", out_pc, 32'h0);

    // Mixed ready/enable pattern, checked by the model
    for (int i = 0; i < 32; i++) begin
      out_ready = rdy_pat[i];
      en        = en_pat[i];
      cyc();
    end
    en = 1; out_ready = 1;
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and address width.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries; power of two, >= 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  global enable; 0 freezes all state.
REQ-007 SHALL have port imem_req  output  1  fetch request this cycle.
REQ-008 SHALL have port imem_addr  output  XLEN  fetch address, always equal to fetch_pc.
REQ-009 SHALL have port imem_rdata  input  32  instruction word, combinationally valid in the same cycle as imem_addr.
REQ-010 SHALL have port redirect  input  1  flush the queue and restart fetch.
REQ-011 SHALL have port redirect_pc  input  XLEN  restart address.
REQ-012 SHALL have port out_valid  output  1  head entry valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts head.
REQ-014 SHALL have port out_pc  output  XLEN  PC of head entry.
REQ-015 SHALL have port out_instr  output  32  instruction of head entry.
REQ-016 SHALL have port count  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-017 SHALL keep internal state fetch_pc, a DEPTH-entry {pc, instr} circular buffer, read/write pointers and count.
REQ-018 SHALL drive imem_req = en & ~rst & ~redirect & (count < DEPTH); no bypass when full, even if a pop occurs in the same cycle.
REQ-019 SHALL push on imem_req: write {fetch_pc, imem_rdata} at the write pointer, increment the write pointer modulo DEPTH, and set fetch_pc <= fetch_pc + 4 modulo 2^XLEN (wraps to 0).
REQ-020 SHALL pop when en & out_valid & out_ready & ~redirect: increment the read pointer modulo DEPTH.
REQ-021 SHALL update count as follows: push only +1, pop only -1, push and pop together unchanged.
REQ-022 SHALL drive out_valid = (count != 0), with out_pc/out_instr taken from the entry at the read pointer; fetch-to-output latency is 1 cycle.
REQ-023 SHALL hold out_pc/out_instr stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, when out_valid=0, drive out_pc/out_instr as don't-care; the bench shall not check them.
REQ-025 SHALL, on en=1 & redirect=1, take priority over push and pop: set pointers and count to 0 and fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; out_valid=0 on the next cycle.
REQ-026 SHALL issue the first fetch from the redirect target in the cycle after a redirect.
REQ-027 SHALL, when en=0, perform no push, pop or redirect; imem_req=0 and outputs hold their values.
REQ-028 SHALL keep all outputs other than imem_addr/imem_rdata-derived paths registered or derived from registers only.

Reset
REQ-029 SHALL, on rst=1 at a clock edge regardless of en/redirect, set fetch_pc <= RESET_PC, pointers to 0 and count to 0.
REQ-030 SHALL, on that reset, result in out_valid=0 and imem_req=0 while rst=1.
REQ-031 SHALL, on rst asserted mid-stream, discard queue contents; the first post-reset fetch address is RESET_PC.
REQ-032 SHALL leave buffer storage uninitialised by reset.

Verification
REQ-033 SHALL cover fill: rst 1 cycle, en=1, out_ready=0 -> fetches at 0x0,0x4,0x8,0xC; count reaches 4; imem_req=0 afterwards; out_pc=0x0 held.
REQ-034 SHALL cover streaming: out_ready=1 constantly after reset -> out_valid from cycle 2, out_pc increments by 4 each cycle, count stays 1.
REQ-035 SHALL cover redirect: with the queue full, redirect=1 and redirect_pc=0x0000_0103 -> next cycle count=0 and out_valid=0; imem_addr=0x0000_0100; next out_pc=0x100.
REQ-036 SHALL cover simultaneous events: redirect, push and pop in the same cycle -> redirect wins and no entry from that cycle appears.
REQ-037 SHALL cover en=0 for 5 cycles mid-stream -> count, out_pc, imem_addr unchanged and imem_req=0; on resume, the sequence continues without a gap or duplicate.
REQ-038 SHALL cover wrap and reset: RESET_PC=32'hFFFF_FFF8 -> fetches at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; rst mid-stream -> count=0 and the next fetch is at RESET_PC.
